forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DEPTH, default 2, SHALL set the number of tracked in-flight stages after EX (stage 1 = MEM, stage DEPTH = last write-back stage).
REQ-003 Parameter NSRC, default 2, SHALL set the number of source operands per instruction.
REQ-004 Parameter LOAD_LAT, default 1, SHALL set the stage index (1..DEPTH) at which load data first becomes forwardable.
REQ-005 Derived constant SELW SHALL equal clog2(DEPTH+1).
REQ-006 Ports SHALL be:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
dec_valid  in  1  instruction in ID requests issue to EX
dec_rs  in  5*NSRC  source register numbers; source i is bits [5i+4:5i]
dec_rd  in  5  destination register
dec_regwrite  in  1  instruction writes dec_rd
dec_load  in  1  instruction is a load
flush  in  1  squash the instruction entering stage 1 this cycle
fwd_sel  out  SELW*NSRC  per-source forward select: 0 = register file, k = stage k
stall  out  1  hold ID; insert a bubble into EX
stall_count  out  16  saturating count of stall cycles

Function
REQ-007 The block SHALL hold a DEPTH-entry shift register; each entry is {valid, rd, wr, load, age}.
REQ-008 Every clock edge, entry k SHALL move to k+1, and the entry leaving stage DEPTH SHALL be discarded.
REQ-009 Stage 1 SHALL load {dec_valid & ~stall & ~flush, dec_rd, dec_regwrite, dec_load} on that edge.
REQ-010 When stall or flush is high, stage 1 SHALL receive a bubble (valid=0), and older stages SHALL still advance.
REQ-011 A matching entry for source i SHALL be valid & wr & rd==dec_rs[i] & rd!=0.
REQ-012 The youngest matching entry (lowest k) SHALL win, and older matches SHALL be ignored.
REQ-013 An entry at stage k SHALL be ready when load==0, or when load==1 and k>=LOAD_LAT.
REQ-014 fwd_sel[i] SHALL be k when the youngest match is ready, and 0 when there is no match or dec_rs[i]==0.
REQ-015 stall SHALL be high when dec_valid is high and any source's youngest match is not ready; fwd_sel for that source SHALL then be 0.
REQ-016 stall and fwd_sel SHALL be combinational from the registered entries and the dec_* inputs, with zero-cycle latency.
REQ-017 Under a stall, a load-use hazard SHALL stall for exactly LOAD_LAT-k cycles and then forward from stage LOAD_LAT.
REQ-018 flush and stall asserted together SHALL give a single bubble, with stall_count still incremented.
REQ-019 stall_count SHALL increment once per cycle in which stall is high and SHALL saturate at 16'hFFFF without wrap-around.
REQ-020 When dec_valid is low, stall SHALL be 0 and all fwd_sel fields SHALL be 0.

Reset
REQ-021 On a clock edge with rst_n low, all entries SHALL become invalid, and stall_count SHALL become 0.
REQ-022 After reset, with dec_valid low, the outputs SHALL be stall=0 and fwd_sel=0.
REQ-023 Reset mid-stall SHALL drop all in-flight entries, so stall deasserts the cycle after the reset edge.

Structure
REQ-024 SELW, the entry record typedef, and the fwd_sel encoding constants (FWD_RF=0) SHALL reside in shared package pipe_pkg.
REQ-025 A single sub-module, fwd_match, SHALL perform the per-source youngest-match priority search and SHALL be instantiated NSRC times.

Verification
REQ-026 Back-to-back ALU ops, add x5 followed by add x6,x5,x5 (DEPTH=2): fwd_sel SHALL be {1,1} and stall SHALL be 0.
REQ-027 A write to x5 followed two cycles later by a read of x5 SHALL give fwd_sel=2.
REQ-028 A write to x5 three cycles earlier SHALL give fwd_sel=0.
REQ-029 Load-use with lw x7 followed by use of x7, LOAD_LAT=2, DEPTH=3: stall SHALL be high for 1 cycle, then fwd_sel=2, with stall_count=1.
REQ-030 Two writes to x5 one cycle apart followed by a read of x5 SHALL give fwd_sel=1 (youngest wins).
REQ-031 A write to x0 followed by a read of x0 SHALL give fwd_sel=0 and stall=0.
REQ-032 flush while issuing a write to x9, followed by a read of x9, SHALL give fwd_sel=0.
REQ-033 With stall held for 70000 cycles, stall_count SHALL equal 16'hFFFF.
REQ-034 rst_n low during a load-use stall SHALL give stall=0 the next cycle and stall_count=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the forwarding scoreboard: in-flight entry record,
// forward-select encoding and the select-width helper.
package pipe_pkg;

    localparam int REGW          = 5;
    localparam int AGEW          = 8;
    localparam int DEPTH_DEFAULT = 2;
    localparam int FWD_RF        = 0;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Select width for the default depth; instances derive their own from DEPTH.
    localparam int SELW = sel_width(DEPTH_DEFAULT);

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rd;
        logic            wr;
        logic            load;
        logic [AGEW-1:0] age;
    } entry_t;

endpackage

// File: rtl/fwd_match.sv
// Youngest-match priority search for one source operand over the in-flight
// entries; reports the winning stage or a not-yet-ready hazard.
module fwd_match
    import pipe_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int SW       = 2
) (
    input  entry_t [DEPTH:1] ent_i,
    input  logic [REGW-1:0]  rs_i,
    output logic [SW-1:0]    sel_o,
    output logic             hazard_o
);

    // Scan oldest to youngest so the youngest match overrides any older one.
    always_comb begin
        sel_o    = SW'(FWD_RF);
        hazard_o = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (ent_i[k].valid && ent_i[k].wr && (ent_i[k].rd == rs_i) && (rs_i != '0)) begin
                // age counts edges since entering stage 1, so stage index is age+1
                if (!ent_i[k].load || ((int'(ent_i[k].age) + 1) >= LOAD_LAT)) begin
                    sel_o    = SW'(k);
                    hazard_o = 1'b0;
                end else begin
                    sel_o    = SW'(FWD_RF);
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Tracks instructions in flight after EX and produces per-source forward
// selects plus a load-use stall for the instruction sitting in ID.
module forward_scoreboard
    import pipe_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    localparam int SW      = sel_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_valid,
    input  logic [5*NSRC-1:0]    dec_rs,
    input  logic [4:0]           dec_rd,
    input  logic                 dec_regwrite,
    input  logic                 dec_load,
    input  logic                 flush,
    output logic [SW*NSRC-1:0]   fwd_sel,
    output logic                 stall,
    output logic [15:0]          stall_count
);

    entry_t [DEPTH:1] ent_q;
    entry_t [DEPTH:1] ent_d;
    logic [NSRC-1:0]    hazard;
    logic [SW*NSRC-1:0] sel_raw;
    logic [15:0]        stall_count_q;
    logic [15:0]        stall_count_d;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        fwd_match #(
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SW       (SW)
        ) u_match (
            .ent_i    (ent_q),
            .rs_i     (dec_rs[5*gi +: 5]),
            .sel_o    (sel_raw[SW*gi +: SW]),
            .hazard_o (hazard[gi])
        );
        assign fwd_sel[SW*gi +: SW] = dec_valid ? sel_raw[SW*gi +: SW] : SW'(FWD_RF);
    end

    assign stall       = dec_valid & (|hazard);
    assign stall_count = stall_count_q;

    // Stage 1 takes the issuing instruction or a bubble; older stages shift on.
    always_comb begin
        ent_d          = ent_q;
        ent_d[1].valid = dec_valid & ~stall & ~flush;
        ent_d[1].rd    = dec_rd;
        ent_d[1].wr    = dec_regwrite;
        ent_d[1].load  = dec_load;
        ent_d[1].age   = '0;
        for (int k = 2; k <= DEPTH; k++) begin
            ent_d[k]     = ent_q[k-1];
            ent_d[k].age = (ent_q[k-1].age == '1) ? '1 : ent_q[k-1].age + AGEW'(1);
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_q         <= '0;
            stall_count_q <= '0;
        end else begin
            ent_q         <= ent_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench: three scoreboard configurations share one stimulus stream;
// each step checks the relevant instance against hand-computed values.
module tb_forward_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic [9:0]  dec_rs;
    logic [4:0]  dec_rd;
    logic        dec_regwrite;
    logic        dec_load;
    logic        flush;

    logic [3:0]  sel2;
    logic        stall2;
    logic [15:0] cnt2;
    logic [3:0]  sel3;
    logic        stall3;
    logic [15:0] cnt3;
    logic [7:0]  sel8;
    logic        stall8;
    logic [15:0] cnt8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    forward_scoreboard #(.DEPTH(2), .NSRC(2), .LOAD_LAT(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rs(dec_rs),
        .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_load(dec_load),
        .flush(flush), .fwd_sel(sel2), .stall(stall2), .stall_count(cnt2)
    );

    forward_scoreboard #(.DEPTH(3), .NSRC(2), .LOAD_LAT(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rs(dec_rs),
        .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_load(dec_load),
        .flush(flush), .fwd_sel(sel3), .stall(stall3), .stall_count(cnt3)
    );

    forward_scoreboard #(.DEPTH(8), .NSRC(2), .LOAD_LAT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rs(dec_rs),
        .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_load(dec_load),
        .flush(flush), .fwd_sel(sel8), .stall(stall8), .stall_count(cnt8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one decode-stage instruction and let combinational outputs settle.
    task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs0,
                       input logic [4:0] rd, input logic wr, input logic ld, input logic fl);
        dec_valid    = v;
        dec_rs       = {rs1, rs0};
        dec_rd       = rd;
        dec_regwrite = wr;
        dec_load     = ld;
        flush        = fl;
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);

        // Reset state
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("reset_stall2", stall2, 0);
        chk("reset_sel2", sel2, 0);
        chk("reset_cnt2", cnt2, 0);
        chk("reset_cnt3", cnt3, 0);
        chk("reset_cnt8", cnt8, 0);
        chk("reset_sel8", sel8, 0);

        // Back-to-back ALU ops: add x5 then add x6,x5,x5
        drv(1, 2, 1, 5, 1, 0, 0);
        chk("b2b_first_stall2", stall2, 0);
        chk("b2b_first_sel2", sel2, 0);
        tick();
        drv(1, 5, 5, 6, 1, 0, 0);
        chk("b2b_sel2", sel2, 4'b0101);
        chk("b2b_stall2", stall2, 0);
        chk("b2b_sel3", sel3, 4'b0101);

        // Write x5, gap, read x5 at distance 2 and then 3
        do_reset();
        drv(1, 0, 0, 5, 1, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        drv(0, 0, 5, 0, 0, 0, 0);
        chk("novalid_sel2", sel2, 0);
        chk("novalid_stall2", stall2, 0);
        drv(1, 0, 5, 0, 0, 0, 0);
        chk("dist2_sel2", sel2, 4'b0010);
        tick();
        drv(1, 0, 5, 0, 0, 0, 0);
        chk("dist3_sel2", sel2, 0);
        chk("dist3_sel3", sel3, 4'b0011);

        // Two writes to x5: youngest wins
        do_reset();
        drv(1, 0, 0, 5, 1, 0, 0);
        tick();
        drv(1, 0, 0, 5, 1, 0, 0);
        tick();
        drv(1, 5, 5, 0, 0, 0, 0);
        chk("youngest_sel2", sel2, 4'b0101);
        chk("youngest_sel3", sel3, 4'b0101);

        // x0 never forwards
        do_reset();
        drv(1, 0, 0, 0, 1, 0, 0);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0);
        chk("x0_sel2", sel2, 0);
        chk("x0_stall2", stall2, 0);

        // Flushed write to x9 leaves nothing to forward
        do_reset();
        drv(1, 0, 0, 9, 1, 0, 1);
        tick();
        drv(1, 9, 9, 0, 0, 0, 0);
        chk("flush_sel2", sel2, 0);
        chk("flush_sel3", sel3, 0);

        // Load-use, LOAD_LAT=2 DEPTH=3
        do_reset();
        drv(1, 0, 0, 7, 1, 1, 0);
        chk("lw_issue_stall3", stall3, 0);
        tick();
        drv(0, 3, 7, 0, 0, 0, 0);
        chk("lu_novalid_stall3", stall3, 0);
        drv(1, 3, 7, 0, 0, 0, 0);
        chk("lu_stall3", stall3, 1);
        chk("lu_sel3", sel3, 0);
        chk("lu_cnt3_pre", cnt3, 0);
        chk("lu_stall2", stall2, 0);
        chk("lu_sel2", sel2, 4'b0001);
        tick();
        drv(1, 3, 7, 0, 0, 0, 0);
        chk("lu_after_stall3", stall3, 0);
        chk("lu_after_sel3", sel3, 4'b0010);
        chk("lu_after_cnt3", cnt3, 1);
        tick();
        drv(1, 3, 7, 0, 0, 0, 0);
        chk("lu_hold_cnt3", cnt3, 1);

        // Flush and stall together: one bubble, count still advances
        do_reset();
        drv(1, 0, 0, 7, 1, 1, 0);
        tick();
        drv(1, 3, 7, 0, 0, 0, 1);
        chk("fs_stall3", stall3, 1);
        tick();
        drv(1, 0, 7, 0, 0, 0, 0);
        chk("fs_after_stall3", stall3, 0);
        chk("fs_after_sel3", sel3, 4'b0010);
        chk("fs_cnt3", cnt3, 1);

        // Reset in the middle of a load-use stall
        do_reset();
        drv(1, 0, 0, 7, 1, 1, 0);
        tick();
        drv(1, 3, 7, 0, 0, 0, 0);
        chk("rst_pre_stall3", stall3, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        chk("rst_mid_stall3", stall3, 0);
        chk("rst_mid_sel3", sel3, 0);
        chk("rst_mid_cnt3", cnt3, 0);

        // Long stall run on DEPTH=8 LOAD_LAT=8: stalls 7 of every 8 cycles
        do_reset();
        drv(1, 7, 7, 7, 1, 1, 0);
        chk("sat_issue_stall8", stall8, 0);
        tick();
        #2;
        chk("sat_first_stall8", stall8, 1);
        chk("sat_first_sel8", sel8, 0);
        repeat (7) tick();
        #2;
        chk("sat_cnt8_7", cnt8, 7);
        chk("sat_ready_stall8", stall8, 0);
        chk("sat_ready_sel8", sel8, 8'h88);
        repeat (75000) tick();
        #2;
        chk("sat_cnt8", cnt8, 16'hFFFF);
        chk("sat_cnt2", cnt2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
